// File: rtl/fpa_seq_core.sv
// Multi-cycle floating-point add/subtract engine with valid/ready handshakes.
// Alignment and normalisation advance one bit per cycle; rounding is truncation.
module fpa_seq_core #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf,
    output logic         zero,
    output logic         busy
);

    localparam int MW = MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_reg;
    logic [W-1:0]     a_reg, b_reg;
    logic             sub_reg;
    logic             sx_reg, sy_reg;
    logic [EXP_W-1:0] ex_reg, d_reg;
    logic [MW-1:0]    mx_reg, my_reg;
    logic [W-1:0]     res_reg;
    logic             ovf_reg, unf_reg, zero_reg;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MW-1:0]    a_man, b_man;
    logic             a_inf, b_inf, b_sign, swap;
    logic [MW-1:0]    m_sum;
    logic [MW-1:0]    m_norm;
    logic [EXP_W-1:0] e_norm;
    logic             norm_ovf, norm_unf;

    // Operand decode: a zero exponent means the whole operand is zero.
    assign a_exp  = a_reg[W-2:MAN_W];
    assign b_exp  = b_reg[W-2:MAN_W];
    assign a_man  = (a_exp != '0) ? {2'b01, a_reg[MAN_W-1:0]} : '0;
    assign b_man  = (b_exp != '0) ? {2'b01, b_reg[MAN_W-1:0]} : '0;
    assign a_inf  = (a_exp == EXP_ONES);
    assign b_inf  = (b_exp == EXP_ONES);
    assign b_sign = b_reg[W-1] ^ sub_reg;
    assign swap   = (a_reg[W-2:0] < b_reg[W-2:0]);

    // mx >= my always holds after the magnitude swap, so the difference never wraps.
    assign m_sum = (sx_reg == sy_reg) ? (mx_reg + my_reg) : (mx_reg - my_reg);

    always_comb begin
        m_norm   = mx_reg;
        e_norm   = ex_reg;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (mx_reg[MW-1]) begin
            m_norm   = mx_reg >> 1;
            e_norm   = ex_reg + 1'b1;
            norm_ovf = (e_norm == EXP_ONES);
        end else if (!mx_reg[MW-2]) begin
            m_norm   = mx_reg << 1;
            e_norm   = ex_reg - 1'b1;
            norm_unf = (ex_reg == EXP_ONE);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            sx_reg    <= 1'b0;
            sy_reg    <= 1'b0;
            ex_reg    <= '0;
            d_reg     <= '0;
            mx_reg    <= '0;
            my_reg    <= '0;
            res_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        sub_reg   <= sub;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ovf_reg  <= 1'b0;
                    unf_reg  <= 1'b0;
                    zero_reg <= 1'b0;
                    if (a_inf || b_inf) begin
                        res_reg   <= a_inf ? a_reg : b_reg;
                        ovf_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        if (swap) begin
                            sx_reg <= b_sign;
                            ex_reg <= b_exp;
                            mx_reg <= b_man;
                            sy_reg <= a_reg[W-1];
                            my_reg <= a_man;
                            d_reg  <= b_exp - a_exp;
                        end else begin
                            sx_reg <= a_reg[W-1];
                            ex_reg <= a_exp;
                            mx_reg <= a_man;
                            sy_reg <= b_sign;
                            my_reg <= b_man;
                            d_reg  <= a_exp - b_exp;
                        end
                        state_reg <= (a_exp != b_exp) ? S_ALIGN : S_ADD;
                    end
                end
                S_ALIGN: begin
                    my_reg <= my_reg >> 1;
                    d_reg  <= d_reg - 1'b1;
                    if ((d_reg == EXP_ONE) || (my_reg[MW-1:1] == '0))
                        state_reg <= S_ADD;
                end
                S_ADD: begin
                    mx_reg <= m_sum;
                    if (m_sum == '0) begin
                        res_reg   <= '0;
                        zero_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (m_sum[MW-1] || !m_sum[MW-2]) begin
                        state_reg <= S_NORM;
                    end else begin
                        res_reg   <= {sx_reg, ex_reg, m_sum[MAN_W-1:0]};
                        state_reg <= S_DONE;
                    end
                end
                S_NORM: begin
                    if (norm_ovf) begin
                        res_reg   <= {sx_reg, EXP_ONES, {MAN_W{1'b0}}};
                        ovf_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (norm_unf) begin
                        res_reg   <= {sx_reg, {(W-1){1'b0}}};
                        unf_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        mx_reg <= m_norm;
                        ex_reg <= e_norm;
                        if (m_norm[MW-1:MW-2] == 2'b01) begin
                            res_reg   <= {sx_reg, e_norm, m_norm[MAN_W-1:0]};
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        ovf_reg   <= 1'b0;
                        unf_reg   <= 1'b0;
                        zero_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Result and flags are only presented while the result is being offered.
    assign in_ready  = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign result    = out_valid ? res_reg : '0;
    assign ovf       = out_valid & ovf_reg;
    assign unf       = out_valid & unf_reg;
    assign zero      = out_valid & zero_reg;

endmodule

// File: tb/tb_fpa_seq_core.sv
// Bench for fpa_seq_core: directed test-plan vectors, handshake/reset checks and
// randomized operations against an arithmetic reference model.
module tb_fpa_seq_core;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf, unf, zero, busy;

    int n_cmp = 0;
    int n_bad = 0;

    fpa_seq_core #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf), .unf(unf),
        .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input longint v);
        int n = 0;
        longint t = v;
        while (t != 0) begin
            t = t >> 1;
            n++;
        end
        return n;
    endfunction

    // Reference: value-level add/sub with truncating alignment and cycle accounting.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic o, output logic u,
                         output logic z, output int lat);
        int ea, eb, ex, ey, d, al, p, sh;
        logic sa, sb, sx, sy;
        longint ma, mb, mx, my, m, mf;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        r = '0; o = 0; u = 0; z = 0;
        if (ea == 255) begin r = a; o = 1; lat = 2; return; end
        if (eb == 255) begin r = b; o = 1; lat = 2; return; end
        sa = a[31];
        sb = b[31] ^ s;
        ma = (ea != 0) ? (longint'(1) << 23) + longint'(a[22:0]) : 0;
        mb = (eb != 0) ? (longint'(1) << 23) + longint'(b[22:0]) : 0;
        if (a[30:0] >= b[30:0]) begin
            sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
        end else begin
            sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
        end
        d = ex - ey;
        if (d == 0) al = 0;
        else begin
            al = (d < bitlen(my)) ? d : bitlen(my);
            if (al == 0) al = 1;
        end
        my = (d >= 60) ? 0 : (my >> d);
        m = (sx == sy) ? mx + my : mx - my;
        lat = 3 + al;
        if (m == 0) begin z = 1; return; end
        p = bitlen(m) - 1;
        if (p == 24) begin
            lat += 1;
            if (ex + 1 == 255) begin
                o = 1; r = {sx, 8'hFF, 23'h0};
            end else begin
                mf = m >> 1;
                r = {sx, 8'(ex + 1), 23'(mf)};
            end
        end else if (p == 23) begin
            r = {sx, 8'(ex), 23'(m)};
        end else begin
            sh = 23 - p;
            if (sh >= ex) begin
                lat += ex; u = 1; r = {sx, 31'h0};
            end else begin
                lat += sh;
                mf = m << sh;
                r = {sx, 8'(ex - sh), 23'(mf)};
            end
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, output logic [31:0] r, output logic o,
                         output logic u, output logic z, output int lat);
        @(negedge clk);
        chk("pre_in_ready", 64'(in_ready), 64'(1));
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("out_valid_timeout", 64'(out_valid), 64'(1));
        r = result; o = ovf; u = unf; z = zero;
        if (hold > 0) begin
            in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                chk("hold_out_valid", 64'(out_valid), 64'(1));
                chk("hold_result", 64'(result), 64'(r));
                chk("hold_flags", 64'({ovf, unf, zero}), 64'({o, u, z}));
                chk("hold_in_ready", 64'(in_ready), 64'(0));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("acc_out_valid", 64'(out_valid), 64'(0));
        chk("acc_in_ready", 64'(in_ready), 64'(1));
        chk("acc_flags", 64'({ovf, unf, zero}), 64'(0));
        out_ready = 1'b0;
        $display("op a=%h b=%h sub=%0d -> result=%h ovf=%0d unf=%0d zero=%0d lat=%0d",
                 a, b, s, r, o, u, z, lat);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input int hold, input logic [31:0] er,
                            input logic [2:0] ef, input int elat);
        logic [31:0] r;
        logic o, u, z;
        int lat;
        do_op(a, b, s, hold, r, o, u, z, lat);
        chk({tag, "_result"}, 64'(r), 64'(er));
        chk({tag, "_flags"}, 64'({o, u, z}), 64'(ef));
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        logic [31:0] a, b, r, er;
        logic s, o, u, z, eo, eu, ez;
        int lat, elat, ea, eb, fa, fb, mode, hold;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        @(negedge clk);
        clr = 1'b0;

        directed("add_1_2", 32'h3F800000, 32'h40000000, 1'b0, 0, 32'h40400000, 3'b000, 4);
        directed("add_1_1", 32'h3F800000, 32'h3F800000, 1'b0, 0, 32'h40000000, 3'b000, 4);
        directed("sub_3_3", 32'h40400000, 32'h40400000, 1'b1, 0, 32'h00000000, 3'b001, 3);
        directed("ovf", 32'h7F000000, 32'h7F000000, 1'b0, 0, 32'h7F800000, 3'b100, 4);
        directed("unf", 32'h00800000, 32'h00C00000, 1'b1, 0, 32'h80000000, 3'b010, 4);
        directed("hold5", 32'h3F800000, 32'h40000000, 1'b0, 5, 32'h40400000, 3'b000, 4);

        for (int i = 0; i < 150; i++) begin
            ea = int'($urandom_range(1, 254));
            fa = int'($urandom_range(0, 32'h7FFFFF));
            fb = int'($urandom_range(0, 32'h7FFFFF));
            eb = ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            mode = int'($urandom_range(0, 9));
            case (mode)
                0: begin eb = ea; fb = fa; end
                1: begin eb = 0; fb = 0; end
                2: begin ea = 0; fa = 0; end
                3: if ($urandom_range(0, 1) == 1) ea = 255; else eb = 255;
                4: begin
                    ea = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(252, 254));
                    eb = ea;
                end
                5: begin eb = ea; fb = fa ^ int'($urandom_range(0, 15)); end
                6: eb = ea;
                default: ;
            endcase
            a = {1'($urandom_range(0, 1)), 8'(ea), 23'(fa)};
            b = {1'($urandom_range(0, 1)), 8'(eb), 23'(fb)};
            s = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 2));
            model(a, b, s, er, eo, eu, ez, elat);
            do_op(a, b, s, hold, r, o, u, z, lat);
            chk("rnd_result", 64'(r), 64'(er));
            chk("rnd_ovf", 64'(o), 64'(eo));
            chk("rnd_unf", 64'(u), 64'(eu));
            chk("rnd_zero", 64'(z), 64'(ez));
            chk("rnd_latency", 64'(lat), 64'(elat));
        end

        // Abort an operation while it is still aligning a far-smaller operand.
        @(negedge clk);
        op_a = 32'h3F800000; op_b = 32'h35800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_align_busy", 64'(busy), 64'(1));
        chk("mid_align_out_valid", 64'(out_valid), 64'(0));
        #1;
        clr = 1'b1;
        #1;
        chk("clr_in_ready", 64'(in_ready), 64'(1));
        chk("clr_out_valid", 64'(out_valid), 64'(0));
        chk("clr_busy", 64'(busy), 64'(0));
        $display("clr asserted mid-align: in_ready=%0d out_valid=%0d busy=%0d",
                 in_ready, out_valid, busy);
        @(negedge clk);
        clr = 1'b0;

        directed("after_clr", 32'h3F800000, 32'h40000000, 1'b0, 0, 32'h40400000, 3'b000, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpa_seq_core.md
Name: fpa_seq_core

Overview:
- Parametrised, multi-cycle floating-point add/subtract engine. Controller and datapath live in one block.
- Generalises the fixed-format adder sequence in three ways:
  - configurable exponent and fraction widths
  - selectable subtraction
  - valid/ready handshakes on input and output
- Aligns and normalises one bit per cycle.
- Reports overflow, underflow and zero per result.
- Sits between the operand staging logic and the result writeback.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; a hidden 1 is implied when the exponent is nonzero
- W, EXP_W+MAN_W+1, total word width; derived, not overridable

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset: asynchronous, active-high
- in_valid  in  1  operands presented
- in_ready  out  1  high only in IDLE
- op_a  in  W  operand A {sign, exp, frac}
- op_b  in  W  operand B
- sub  in  1  1: compute A-B; 0: compute A+B
- out_valid  out  1  result/flags valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  W  sum/difference
- ovf  out  1  overflow; result is signed infinity
- unf  out  1  underflow; result is flushed to signed zero
- zero  out  1  result is zero
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: on clr all state returns to IDLE, asynchronously and from any state including mid-operation. All outputs become 0 except in_ready=1. Partial results are discarded.
- Input transfer: occurs on a rising edge with in_valid & in_ready. The edge latches op_a, op_b and sub. Inputs are ignored outside IDLE.
- Operand decode:
  - exp==0 means the operand is zero (no denormals).
  - exp==all-ones means infinity (no NaN). Any infinite operand makes the block go straight from LOAD to DONE with result = that operand (A wins if both are infinite) and ovf=1.
- Effective B sign = sign_b ^ sub.
- States: IDLE, LOAD, ALIGN, ADD, NORM, DONE.
- IDLE -> LOAD on transfer.
- LOAD (1 cycle):
  - Build mantissas {0, hidden, frac}, width MAN_W+2.
  - Swap operands so |X| >= |Y|, compared on {exp, frac}.
  - Compute d = ex - ey.
  - Next state: ALIGN if d>0, else ADD.
- ALIGN: each cycle shifts my right 1, truncating, and decrements d. Go to ADD when d==0 or my==0, so at most MAN_W+2 cycles.
- ADD (1 cycle):
  - Signs equal: m = mx + my; otherwise m = mx - my.
  - Result sign = sign of X.
  - m==0 -> DONE with result = +0 and zero=1.
  - m[MAN_W+1]==1 or m[MAN_W]==0 -> NORM; else -> DONE.
- NORM: one shift per cycle.
  - If m[MAN_W+1]: shift right 1, exp+1. If exp becomes all-ones -> DONE with ovf=1 and result = signed infinity (frac=0).
  - Else if m[MAN_W]==0: shift left 1, exp-1. If exp would reach 0 -> DONE with unf=1 and result = signed zero.
  - Repeat until m[MAN_W+1:MAN_W]==01, then -> DONE.
- Rounding: truncation only.
- DONE:
  - out_valid=1; result and flags are stable.
  - Stay in DONE while !out_ready.
  - On out_valid & out_ready -> IDLE; out_valid drops the next cycle.
- Latency from the transfer edge to out_valid: 3 + align shifts + norm shifts. There is no pipelining; one operation is in flight at a time.
- Simultaneous events: out_ready may already be high when DONE is entered, giving single-cycle acceptance. in_ready rises the cycle after acceptance (no same-cycle reuse).
- Flags are mutually exclusive and valid only while out_valid=1. They are zero otherwise.

Test Plan:
- Defaults. op_a=0x3F800000, op_b=0x40000000, sub=0 -> result 0x40400000 (3.0), flags 0, out_valid 4 cycles after transfer (1 align shift).
- op_a=op_b=0x3F800000, sub=0 -> carry triggers 1 right normalise -> result 0x40000000, latency 4.
- op_a=op_b=0x40400000, sub=1 -> result 0x00000000, zero=1, latency 3.
- op_a=op_b=0x7F000000, sub=0 -> ovf=1, result 0x7F800000.
- op_a=0x00800000, op_b=0x00C00000, sub=1 -> unf=1, result 0x80000000.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: result and out_valid stay stable, in_ready=0.
  - Assert clr mid-ALIGN: next sample shows IDLE, in_ready=1, out_valid=0.
  - A fresh 1.0+2.0 then gives 0x40400000.
